// File: rtl/sacc_pkg.sv
// Shared lane layout and mode types for the packed-lane saturating accumulator.
package sacc_pkg;

    localparam int NUM_LANES = 4;
    localparam int WORD_W    = 64;
    localparam int CHAIN_W   = 64;

    localparam int LANE_L0 = 0;
    localparam int LANE_L1 = 1;
    localparam int LANE_L2 = 2;
    localparam int LANE_L3 = 3;

    // Bit offset of each lane inside the packed product word.
    function automatic int lane_off(input int idx);
        case (idx)
            LANE_L0: return 0;
            LANE_L1: return 8;
            LANE_L2: return 16;
            default: return 32;
        endcase
    endfunction

    // Width of each lane inside the packed product word.
    function automatic int lane_width(input int idx);
        case (idx)
            LANE_L0: return 8;
            LANE_L1: return 8;
            LANE_L2: return 16;
            default: return 32;
        endcase
    endfunction

    // Arithmetic mode captured at the start of each accumulation.
    typedef struct packed {
        logic [NUM_LANES-1:0] lanes;
        logic                 chain;
    } mode_t;

endpackage

// File: rtl/sacc_if.sv
// Product, mode and result handshake signals between the accumulator and its environment.
interface sacc_if #(
    parameter int ACC_LEN_W = 8
);
    logic                 in_valid;
    logic [63:0]          res_mac_next;
    logic [3:0]           select_precision;
    logic                 active_chain;
    logic [ACC_LEN_W-1:0] acc_len;
    logic                 mul_ce;
    logic                 out_valid;
    logic                 out_ready;
    logic [63:0]          acc_out;
    logic [3:0]           overflow;
    logic                 busy;

    modport slave (
        input  in_valid, res_mac_next, select_precision, active_chain, acc_len, out_ready,
        output mul_ce, out_valid, acc_out, overflow, busy
    );

    modport master (
        output in_valid, res_mac_next, select_precision, active_chain, acc_len, out_ready,
        input  mul_ce, out_valid, acc_out, overflow, busy
    );
endinterface

// File: rtl/sacc_lane.sv
// Combinational signed saturating adder used for each lane and for the full-word chain mode.
module sacc_lane #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             ovf
);

    logic [WIDTH-1:0] raw;

    // Wrap-around sum, replaced by the rail matching the operand sign when it overflows.
    always_comb begin
        raw = a + b;
        ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
        sum = raw;
        if (ovf) begin
            sum = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/sacc.sv
// Packed-lane signed accumulator: sums acc_len products per lane and hands the result
// over a valid/ready port, stalling the multiplier while the result is not taken.
module sacc
    import sacc_pkg::*;
#(
    parameter int MUL_LATENCY = 3,
    parameter int ACC_LEN_W   = 8
) (
    input  logic   clk,
    input  logic   aresetn,
    input  logic   ce,
    input  logic   sclr,
    sacc_if.slave  bus
);

    logic [MUL_LATENCY-1:0] vdl_q;
    logic [MUL_LATENCY-1:0] vdl_next;
    logic [WORD_W-1:0]      acc_q;
    logic [ACC_LEN_W-1:0]   count_q;
    logic [NUM_LANES-1:0]   sticky_q;
    mode_t                  mode_q;
    logic [ACC_LEN_W-1:0]   len_q;
    logic                   out_valid_q;
    logic [WORD_W-1:0]      acc_out_q;
    logic [NUM_LANES-1:0]   ovf_out_q;

    logic                   pipe_en;
    logic                   pv;
    mode_t                  mode_in;
    mode_t                  mode_cur;
    logic [ACC_LEN_W-1:0]   len_in;
    logic [ACC_LEN_W-1:0]   len_cur;
    logic [ACC_LEN_W:0]     count_inc;
    logic                   is_final;
    logic                   final_hit;
    logic [WORD_W-1:0]      lane_sum;
    logic [NUM_LANES-1:0]   lane_ovf;
    logic [CHAIN_W-1:0]     chain_sum;
    logic                   chain_ovf;
    logic [WORD_W-1:0]      next_acc;
    logic [NUM_LANES-1:0]   ovf_now;

    assign pipe_en   = ce & ~(out_valid_q & ~bus.out_ready);
    assign pv        = vdl_q[MUL_LATENCY-1];
    assign mode_in   = {bus.select_precision, bus.active_chain};
    assign len_in    = (bus.acc_len == '0) ? ACC_LEN_W'(1) : bus.acc_len;
    assign mode_cur  = (count_q == '0) ? mode_in : mode_q;
    assign len_cur   = (count_q == '0) ? len_in : len_q;
    assign count_inc = {1'b0, count_q} + 1'b1;
    assign is_final  = (count_inc == {1'b0, len_cur});
    assign final_hit = pipe_en & pv & is_final;

    // A one-deep delay line has no older stage to shift from.
    if (MUL_LATENCY == 1) begin : g_vdl_one
        assign vdl_next = bus.in_valid;
    end else begin : g_vdl_many
        assign vdl_next = {vdl_q[MUL_LATENCY-2:0], bus.in_valid};
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam int OFF = lane_off(i);
        localparam int W   = lane_width(i);
        logic [W-1:0] s;
        logic         o;

        sacc_lane #(.WIDTH(W)) u_lane (
            .a   (acc_q[OFF +: W]),
            .b   (bus.res_mac_next[OFF +: W]),
            .sum (s),
            .ovf (o)
        );

        assign lane_sum[OFF +: W] = mode_cur.lanes[i] ? s : '0;
        assign lane_ovf[i]        = mode_cur.lanes[i] & o;
    end

    sacc_lane #(.WIDTH(CHAIN_W)) u_chain (
        .a   (acc_q),
        .b   (bus.res_mac_next),
        .sum (chain_sum),
        .ovf (chain_ovf)
    );

    // Select lane-wise or full-word result and the overflow flags raised by this product.
    always_comb begin
        next_acc = lane_sum;
        ovf_now  = lane_ovf;
        if (mode_cur.chain) begin
            next_acc = chain_sum;
            ovf_now  = {{(NUM_LANES-1){1'b0}}, chain_ovf};
        end
    end

    // Delay line, mode latch and running accumulation advance only while the pipeline is enabled.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            vdl_q    <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            sticky_q <= '0;
            mode_q   <= '0;
            len_q    <= '0;
        end else if (sclr) begin
            vdl_q    <= '0;
            acc_q    <= '0;
            count_q  <= '0;
            sticky_q <= '0;
            mode_q   <= '0;
            len_q    <= '0;
        end else if (pipe_en) begin
            vdl_q <= vdl_next;
            if (pv) begin
                if (count_q == '0) begin
                    mode_q <= mode_in;
                    len_q  <= len_in;
                end
                if (is_final) begin
                    acc_q    <= '0;
                    count_q  <= '0;
                    sticky_q <= '0;
                end else begin
                    acc_q    <= next_acc;
                    count_q  <= count_inc[ACC_LEN_W-1:0];
                    sticky_q <= sticky_q | ovf_now;
                end
            end
        end
    end

    // Output register: a finishing accumulation loads it, otherwise a consumer pop empties it.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_q <= 1'b0;
            acc_out_q   <= '0;
            ovf_out_q   <= '0;
        end else if (sclr) begin
            out_valid_q <= 1'b0;
            acc_out_q   <= '0;
            ovf_out_q   <= '0;
        end else if (final_hit) begin
            out_valid_q <= 1'b1;
            acc_out_q   <= next_acc;
            ovf_out_q   <= sticky_q | ovf_now;
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.mul_ce    = pipe_en;
    assign bus.out_valid = out_valid_q;
    assign bus.acc_out   = acc_out_q;
    assign bus.overflow  = ovf_out_q;
    assign bus.busy      = (count_q != '0) | (|vdl_q);

endmodule

// File: tb/tb_sacc.sv
// Self-checking bench for sacc: an external multiplier stand-in feeds products, a
// behavioural model predicts every output, and directed scenarios pin literal results.
module tb_sacc;

    localparam int L   = 3;
    localparam int ALW = 8;
    localparam logic [63:0] JUNK = 64'hA5C3_9E17_5B2D_6F81;

    logic            clk     = 1'b0;
    logic            aresetn = 1'b0;
    logic            ce      = 1'b0;
    logic            sclr    = 1'b0;
    logic            in_valid  = 1'b0;
    logic [63:0]     prod_in   = JUNK;
    logic [3:0]      sel       = 4'b0000;
    logic            chain     = 1'b0;
    logic [ALW-1:0]  len       = '0;
    logic            out_ready = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] obs_d [$];
    logic [3:0]  obs_o [$];

    sacc_if #(.ACC_LEN_W(ALW)) bus ();

    sacc #(.MUL_LATENCY(L), .ACC_LEN_W(ALW)) dut (
        .clk     (clk),
        .aresetn (aresetn),
        .ce      (ce),
        .sclr    (sclr),
        .bus     (bus)
    );

    // Multiplier stand-in: operands travel L enabled stages before showing up as a product.
    logic [63:0] mpipe [L] = '{default: '0};

    assign bus.in_valid         = in_valid;
    assign bus.res_mac_next     = mpipe[L-1];
    assign bus.select_precision = sel;
    assign bus.active_chain     = chain;
    assign bus.acc_len          = len;
    assign bus.out_ready        = out_ready;

    always #5 clk = ~clk;

    // The multiplier only moves when the accumulator enables it.
    always @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < L; i++) mpipe[i] <= '0;
        end else if (bus.mul_ce) begin
            mpipe[0] <= prod_in;
            for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
        end
    end

    // Sign-extend a w-bit field sitting at the bottom of v.
    function automatic longint sext(input logic [63:0] v, input int w);
        longint t;
        t = longint'(v << (64 - w));
        return t >>> (64 - w);
    endfunction

    // Saturating add of one product into an accumulator word, computed with integer clamping.
    function automatic logic [63:0] model_add(input logic [63:0] acc, input logic [63:0] prod,
                                              input logic [3:0] lanes, input logic ch,
                                              output logic [3:0] ovf);
        int offs [4];
        int ws   [4];
        longint a, b, s, hi, lo;
        logic [63:0] mask, r;
        logic signed [64:0] cs, chi, clo;
        offs = '{0, 8, 16, 32};
        ws   = '{8, 8, 16, 32};
        r    = '0;
        ovf  = '0;
        if (ch) begin
            cs  = $signed({acc[63], acc}) + $signed({prod[63], prod});
            chi = 65'sh0_7FFF_FFFF_FFFF_FFFF;
            clo = -chi - 65'sd1;
            if (cs > chi) begin
                r = chi[63:0];
                ovf[0] = 1'b1;
            end else if (cs < clo) begin
                r = clo[63:0];
                ovf[0] = 1'b1;
            end else begin
                r = cs[63:0];
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i]) begin
                    a  = sext(acc >> offs[i], ws[i]);
                    b  = sext(prod >> offs[i], ws[i]);
                    s  = a + b;
                    hi = (64'sd1 <<< (ws[i] - 1)) - 64'sd1;
                    lo = -hi - 64'sd1;
                    if (s > hi) begin
                        s = hi;
                        ovf[i] = 1'b1;
                    end else if (s < lo) begin
                        s = lo;
                        ovf[i] = 1'b1;
                    end
                    mask = (64'd1 << ws[i]) - 64'd1;
                    r = r | ((64'(s) & mask) << offs[i]);
                end
            end
        end
        return r;
    endfunction

    // Reference model state.
    logic [L-1:0] m_v     = '0;
    logic [63:0]  m_d [L] = '{default: '0};
    logic [63:0]  m_acc   = '0;
    int           m_count = 0;
    logic [3:0]   m_stk   = '0;
    logic [3:0]   m_lanes = '0;
    logic         m_chain = 1'b0;
    int           m_len   = 0;
    logic         m_ov    = 1'b0;
    logic [63:0]  m_out   = '0;
    logic [3:0]   m_oovf  = '0;

    logic         m_pe, m_take, m_final, m_chain_c;
    logic [3:0]   m_lanes_c, m_ovf_now;
    int           m_len_c;
    logic [63:0]  m_sum;

    // What the model would do with the current inputs at the coming edge.
    always_comb begin
        m_pe      = ce && !(m_ov && !out_ready);
        m_take    = m_pe && m_v[L-1];
        m_lanes_c = (m_count == 0) ? sel : m_lanes;
        m_chain_c = (m_count == 0) ? chain : m_chain;
        m_len_c   = (m_count == 0) ? ((len == 0) ? 1 : int'(len)) : m_len;
        m_ovf_now = '0;
        m_sum     = model_add(m_acc, m_d[L-1], m_lanes_c, m_chain_c, m_ovf_now);
        m_final   = m_take && (m_count + 1 == m_len_c);
    end

    // Model state update.
    always @(posedge clk or negedge aresetn) begin
        if (!aresetn || sclr) begin
            m_v     <= '0;
            m_acc   <= '0;
            m_count <= 0;
            m_stk   <= '0;
            m_lanes <= '0;
            m_chain <= 1'b0;
            m_len   <= 0;
            m_ov    <= 1'b0;
            m_out   <= '0;
            m_oovf  <= '0;
        end else begin
            if (m_pe) begin
                m_v    <= {m_v[L-2:0], in_valid};
                m_d[0] <= prod_in;
                for (int i = 1; i < L; i++) m_d[i] <= m_d[i-1];
            end
            if (m_take) begin
                if (m_count == 0) begin
                    m_lanes <= sel;
                    m_chain <= chain;
                    m_len   <= m_len_c;
                end
                if (m_final) begin
                    m_out   <= m_sum;
                    m_oovf  <= m_stk | m_ovf_now;
                    m_acc   <= '0;
                    m_count <= 0;
                    m_stk   <= '0;
                end else begin
                    m_acc   <= m_sum;
                    m_count <= m_count + 1;
                    m_stk   <= m_stk | m_ovf_now;
                end
            end
            if (m_final) m_ov <= 1'b1;
            else if (m_ov && out_ready) m_ov <= 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the rising edge.
    always @(negedge clk) begin
        checkOutput("mul_ce", 64'(bus.mul_ce), 64'(m_pe));
        checkOutput("out_valid", 64'(bus.out_valid), 64'(m_ov));
        checkOutput("busy", 64'(bus.busy), 64'((m_count != 0) || (m_v != '0)));
        if (m_ov) begin
            checkOutput("acc_out", bus.acc_out, m_out);
            checkOutput("overflow", 64'(bus.overflow), 64'(m_oovf));
        end
    end

    // Record every result the consumer actually takes.
    always @(posedge clk) begin
        if (aresetn && bus.out_valid && out_ready) begin
            obs_d.push_back(bus.acc_out);
            obs_o.push_back(bus.overflow);
        end
    end

    // Drive one cycle of inputs, then return to idle.
    task automatic applyStimulus(input logic iv, input logic [63:0] prod, input logic clr);
        in_valid = iv;
        prod_in  = prod;
        sclr     = clr;
        @(posedge clk); #1;
        in_valid = 1'b0;
        prod_in  = JUNK;
        sclr     = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, JUNK, 1'b0);
    endtask

    // Hold an operand until the multiplier is enabled to take it.
    task automatic issueProduct(input logic [63:0] prod);
        bit accepted;
        accepted = 1'b0;
        for (int k = 0; k < 100 && !accepted; k++) begin
            in_valid = 1'b1;
            prod_in  = prod;
            @(negedge clk);
            accepted = bus.mul_ce;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        prod_in  = JUNK;
        if (!accepted) begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL issue_timeout: got mul_ce=0 for 100 cycles, expected acceptance");
        end
    endtask

    // L0 product in the low byte with junk in the other lanes.
    function automatic logic [63:0] mk_l0(input logic [7:0] v);
        return (JUNK & 64'hFFFF_FFFF_FFFF_FF00) | {56'd0, v};
    endfunction

    task automatic checkObs(input string name, input int idx, input logic [63:0] d, input logic [3:0] o);
        if (idx < obs_d.size()) begin
            checkOutput({name, "_data"}, obs_d[idx], d);
            checkOutput({name, "_ovf"}, 64'(obs_o[idx]), 64'(o));
        end else begin
            n_cmp++;
            n_bad++;
            $display("[TB] FAIL %s: got %0d results, expected entry %0d", name, obs_d.size(), idx);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] first;
        bit          seen;

        // Reset with random inputs.
        for (int k = 0; k < 4; k++) begin
            ce        = 1'($urandom);
            in_valid  = 1'($urandom);
            sclr      = 1'($urandom);
            out_ready = 1'($urandom);
            sel       = 4'($urandom);
            chain     = 1'($urandom);
            len       = ALW'($urandom);
            prod_in   = {$urandom, $urandom};
            @(negedge clk);
            checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
            checkOutput("rst_acc_out", bus.acc_out, 64'd0);
            checkOutput("rst_overflow", 64'(bus.overflow), 64'd0);
            checkOutput("rst_busy", 64'(bus.busy), 64'd0);
            @(posedge clk); #1;
        end
        ce = 1'b1; sclr = 1'b0; in_valid = 1'b0; prod_in = JUNK;
        out_ready = 1'b1; sel = 4'b0000; chain = 1'b0; len = '0;
        aresetn = 1'b1;
        @(negedge clk);
        checkOutput("rst_mul_ce", 64'(bus.mul_ce), 64'd1);
        @(posedge clk); #1;
        idle(2);

        // L0 only, four products, with latency measurement.
        $display("[TB] L0 accumulate 3,-5,10,7");
        obs_d.delete(); obs_o.delete();
        sel = 4'b0001; chain = 1'b0; len = 8'd4;
        issueProduct(mk_l0(8'd3));
        issueProduct(mk_l0(8'hFB));
        issueProduct(mk_l0(8'd10));
        issueProduct(mk_l0(8'd7));
        idle(L - 1);
        checkOutput("t2_latency_early", 64'(bus.out_valid), 64'd0);
        idle(1);
        checkOutput("t2_latency", 64'(bus.out_valid), 64'd1);
        checkOutput("t2_acc_out", bus.acc_out, 64'h0000_0000_0000_000F);
        idle(4);
        checkOutput("t2_count", 64'(obs_d.size()), 64'd1);
        checkObs("t2_result", 0, 64'h0000_0000_0000_000F, 4'b0000);

        // Saturation on L0 and L3.
        $display("[TB] saturation on L0 and L3");
        obs_d.delete(); obs_o.delete();
        sel = 4'b1001; len = 8'd2;
        issueProduct(64'h7FFF_FFFF_5A3C_1764);
        issueProduct(64'h0000_0001_9E2B_7764);
        idle(L + 3);
        checkOutput("t3_count", 64'(obs_d.size()), 64'd1);
        checkObs("t3_result", 0, 64'h7FFF_FFFF_0000_007F, 4'b1001);

        // Chain mode carries across lane boundaries.
        $display("[TB] chain mode carry");
        obs_d.delete(); obs_o.delete();
        sel = 4'b0101; chain = 1'b1; len = 8'd2;
        issueProduct(64'h0000_0000_FFFF_FFFF);
        issueProduct(64'h0000_0000_0000_0001);
        idle(L + 3);
        checkOutput("t4_count", 64'(obs_d.size()), 64'd1);
        checkObs("t4_result", 0, 64'h0000_0001_0000_0000, 4'b0000);

        // Backpressure: first result held, then everything drains in order.
        $display("[TB] backpressure");
        obs_d.delete(); obs_o.delete();
        sel = 4'b0001; chain = 1'b0; len = 8'd1; out_ready = 1'b0;
        first = '0;
        fork
            begin
                for (int i = 1; i <= 6; i++) issueProduct(mk_l0(8'(i)));
            end
            begin
                seen = 1'b0;
                for (int k = 0; k < 40 && !seen; k++) begin
                    @(negedge clk);
                    seen = bus.out_valid;
                end
                if (!seen) begin
                    n_cmp++;
                    n_bad++;
                    $display("[TB] FAIL t5_wait_valid: got out_valid=0 for 40 cycles, expected 1");
                end
                first = bus.acc_out;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    checkOutput("t5_mul_ce_hold", 64'(bus.mul_ce), 64'd0);
                    checkOutput("t5_acc_hold", bus.acc_out, first);
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        checkOutput("t5_first", first, 64'h0000_0000_0000_0001);
        idle(L + 4);
        checkOutput("t5_count", 64'(obs_d.size()), 64'd6);
        for (int i = 0; i < 6; i++) checkObs("t5_order", i, 64'(i + 1), 4'b0000);

        // sclr mid-accumulation, then acc_len of zero.
        $display("[TB] sclr and zero length");
        obs_d.delete(); obs_o.delete();
        sel = 4'b0001; len = 8'd4;
        issueProduct(mk_l0(8'd5));
        issueProduct(mk_l0(8'd5));
        idle(L + 1);
        checkOutput("t6_busy_before", 64'(bus.busy), 64'd1);
        applyStimulus(1'b0, JUNK, 1'b1);
        checkOutput("t6_busy_after", 64'(bus.busy), 64'd0);
        checkOutput("t6_valid_after", 64'(bus.out_valid), 64'd0);
        for (int i = 0; i < 4; i++) issueProduct(mk_l0(8'd1));
        idle(L + 3);
        len = 8'd0;
        issueProduct(mk_l0(8'd9));
        idle(L + 3);
        checkOutput("t6_count", 64'(obs_d.size()), 64'd2);
        checkObs("t6_after_clear", 0, 64'h0000_0000_0000_0004, 4'b0000);
        checkObs("t6_len_zero", 1, 64'h0000_0000_0000_0009, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sacc.md
Name: sacc

Overview:
- Packed-lane signed accumulator that consumes the `res_mac_next` product word of the sub-MAC multiplier.
- Sums `acc_len` consecutive products per lane with saturation, then presents the result on a valid/ready output.
- Tracks multiplier latency internally and drives the multiplier's clock enable (`mul_ce`). Output backpressure therefore freezes the whole multiply/accumulate pipeline and no product is lost.

Parameters:
- MUL_LATENCY, 3, enabled-cycle delay from operand issue (`in_valid`) to the product on `res_mac_next`; range 1..8.
- ACC_LEN_W, 8, width of `acc_len`.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- aresetn  input  1  asynchronous active-low reset.
- ce  input  1  global enable.
- sclr  input  1  synchronous clear, active-high; priority over all activity except aresetn.
- in_valid  input  1  operands are being issued to the multiplier this cycle.
- res_mac_next  input  64  packed signed products; lanes L0 [7:0], L1 [15:8], L2 [31:16], L3 [63:32].
- select_precision  input  4  lane enables; bit i enables lane Li.
- active_chain  input  1  1 = whole word is a single signed 64-bit value.
- acc_len  input  ACC_LEN_W  products per accumulation; 0 is treated as 1.
- mul_ce  output  1  enable for the multiplier: `ce & ~(out_valid & ~out_ready)`.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- acc_out  output  64  packed result; disabled lanes read 0.
- overflow  output  4  per-lane saturation occurred during this accumulation; bit 0 only in chain mode.
- busy  output  1  accumulation in progress, or products still in flight.

Behaviour:
- Reset state (aresetn low, asynchronous): every register is 0. `out_valid`=0, `acc_out`=0, `overflow`=0, `busy`=0.
- sclr=1 at an edge clears the accumulator, count, valid delay line, mode latch, and output register (`out_valid`=0), including mid-accumulation. sclr does not depend on ce.
- pipe_en = `mul_ce`. All internal state except the output handshake advances only when pipe_en=1.
- Valid delay line: MUL_LATENCY-deep shift register of `in_valid`, shifted on pipe_en. Its tail (pv) marks `res_mac_next` as a real product that cycle.
- Mode latch: on a pv cycle with count==0, the block samples `select_precision`, `active_chain` and `acc_len` (len_eff = max(acc_len,1)). Changes during an accumulation are ignored until the next one.
- Lane arithmetic:
  - Each enabled lane computes signed lane_acc + lane_product in its own width.
  - On overflow the sum saturates to the lane max or min (e.g. L0: +127/−128) and sets the sticky overflow bit.
  - Disabled lanes hold 0.
- Chain mode: a single signed 64-bit saturating add over the full word. Lane enables are ignored; overflow[0] is used.
- Count: increments on each pv cycle.
- Non-final pv cycle (count+1 < len_eff): the accumulator takes the sum.
- Final pv cycle (count+1 == len_eff):
  - The sum and final overflow flags go to the output register.
  - out_valid=1 from the next cycle.
  - Accumulator, count and overflow sticky are cleared, so the next product starts a fresh accumulation.
  - Latency: the result is visible 1 cycle after the final product, i.e. MUL_LATENCY+1 enabled cycles after the final `in_valid`.
- Output handshake:
  - out_valid && out_ready at an edge clears out_valid, unless a new final product loads at the same edge. In that case out_valid stays 1 with the new data (simultaneous pop and push).
  - While out_valid && !out_ready, `mul_ce`=0. The pipeline, delay line and accumulator freeze, and `acc_out`/`overflow` are stable.
- busy = (count != 0) | (any delay-line bit set).
- ce=0: nothing advances except the output handshake, which still pops on out_ready.

Decomposition:
- `precision_def.vh` gains:
  - lane offset constants 0/8/16/32 and width constants 8/8/16/32;
  - lane-index defines;
  - the chain-mode width (64).
- One sub-module, `sacc_lane`: parameterised WIDTH, combinational signed saturating adder with an overflow flag. It is instantiated 4× for the lanes and 1× at WIDTH=64 for chain mode.

Test Plan:
1. Reset: aresetn=0 with random inputs → out_valid=0, acc_out=0, overflow=0, busy=0. After release with ce=1 → mul_ce=1.
2. L0 only (select_precision=0001), acc_len=4, products 3, −5, 10, 7 → one result, acc_out=0x0000_0000_0000_000F, overflow=0, out_valid exactly MUL_LATENCY+1 cycles after the 4th in_valid.
3. Saturation: L0 and L3 enabled, acc_len=2, L0 products 100,100 and L3 products 0x7FFF_FFFF,1 → acc_out[7:0]=0x7F, acc_out[63:32]=0x7FFF_FFFF, overflow=1001.
4. Chain mode: acc_len=2, products 0x0000_0000_FFFF_FFFF and 1 → acc_out=0x0000_0001_0000_0000 (carry crosses lanes), overflow=0.
5. Backpressure: acc_len=1, continuous in_valid, out_ready=0 → first result held, mul_ce=0, acc_out stable for 10 cycles. Then out_ready=1 → every product emerges in order, none lost or duplicated.
6. sclr after 2 of 4 L0 products (5,5), then 4 new products 1,1,1,1 → single result acc_out[7:0]=0x04. acc_len=0 with one product of 9 → result 9.
